// File: rtl/mcash_ch_req_queue_pkg.sv
// +----------------------------------------------------------------------+
// | mcash_pkg: shared widths and the channel request record              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package mcash_pkg;

  localparam int MCASH_OP_W   = 3;
  localparam int MCASH_ADDR_W = 32;
  localparam int MCASH_DATA_W = 64;

  typedef struct packed {
    logic [MCASH_OP_W-1:0]   op;
    logic [MCASH_ADDR_W-1:0] addr;
    logic [MCASH_DATA_W-1:0] data;
  } mcash_req_t;

  localparam int MCASH_REQ_W = $bits(mcash_req_t);

endpackage

`default_nettype wire

// File: rtl/mcash_ch_req_queue_if.sv
// +----------------------------------------------------------------------+
// | mcash_ch_req_queue_if: requester-side and cross-bar-side handshakes  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface mcash_ch_req_queue_if;
  import mcash_pkg::*;

  logic                    in_req_valid_i;
  logic                    in_req_allowIn_o;
  logic [MCASH_OP_W-1:0]   in_req_op_i;
  logic [MCASH_ADDR_W-1:0] in_req_addr_i;
  logic [MCASH_DATA_W-1:0] in_req_data_i;

  logic                    out_req_valid_o;
  logic                    out_req_allowIn_i;
  logic [MCASH_OP_W-1:0]   out_req_op_o;
  logic [MCASH_ADDR_W-1:0] out_req_addr_o;
  logic [MCASH_DATA_W-1:0] out_req_data_o;

  // Queue side
  modport slave (
    input  in_req_valid_i, in_req_op_i, in_req_addr_i, in_req_data_i, out_req_allowIn_i,
    output in_req_allowIn_o, out_req_valid_o, out_req_op_o, out_req_addr_o, out_req_data_o
  );

  // Requester / cross-bar side
  modport master (
    output in_req_valid_i, in_req_op_i, in_req_addr_i, in_req_data_i, out_req_allowIn_i,
    input  in_req_allowIn_o, out_req_valid_o, out_req_op_o, out_req_addr_o, out_req_data_o
  );

endinterface

`default_nettype wire

// File: rtl/mcash_ch_req_queue_sync_fifo.sv
// +----------------------------------------------------------------------+
// | mcash_sync_fifo: wrap-bit pointer FIFO with registered occupancy     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mcash_sync_fifo #(
  parameter int WIDTH = 99,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             wr_en,
  input  wire logic [WIDTH-1:0] wr_data,
  input  wire logic             rd_en,
  output logic      [WIDTH-1:0] rd_data,
  output logic      [CNT_W-1:0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int c_ptr_w = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // Same index with opposite wrap bits means the writer has lapped the reader
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_ptr_w-2:0] == r_rd_ptr[c_ptr_w-2:0]) &&
                 (r_wr_ptr[c_ptr_w-1]   != r_rd_ptr[c_ptr_w-1]);

  assign w_push  = wr_en & ~full;
  assign w_pop   = rd_en & ~empty;
  assign rd_data = r_mem[r_rd_ptr[c_ptr_w-2:0]];
  assign count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_ptr_w-2:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mcash_ch_req_queue.sv
// +----------------------------------------------------------------------+
// | mcash_ch_req_queue: in-order request buffer ahead of a cross-bar port|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mcash_ch_req_queue
  import mcash_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  mcash_ch_req_queue_if.slave   req_if,
  output logic      [CNT_W-1:0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  mcash_req_t w_req_in;
  mcash_req_t w_head;
  mcash_req_t w_req_out;
  logic       w_full;
  logic       w_empty;
  logic       w_allow_in;
  logic       w_push;
  logic       w_pop;

  assign w_req_in = '{op:   req_if.in_req_op_i,
                      addr: req_if.in_req_addr_i,
                      data: req_if.in_req_data_i};

  // Ready depends only on state and rst, never on out allowIn
  assign w_allow_in = ~w_full & ~rst;
  assign w_push     = req_if.in_req_valid_i & w_allow_in;
  assign w_pop      = ~w_empty & req_if.out_req_allowIn_i;

  mcash_sync_fifo #(
    .WIDTH (MCASH_REQ_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (w_req_in),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .count   (count_o),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_req_out = w_empty ? '0 : w_head;

  assign req_if.in_req_allowIn_o = w_allow_in;
  assign req_if.out_req_valid_o  = ~w_empty;
  assign req_if.out_req_op_o     = w_req_out.op;
  assign req_if.out_req_addr_o   = w_req_out.addr;
  assign req_if.out_req_data_o   = w_req_out.data;
  assign full_o                  = w_full;
  assign empty_o                 = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_mcash_ch_req_queue.sv
// +----------------------------------------------------------------------+
// | tb_mcash_ch_req_queue: scoreboard bench for the channel request queue|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mcash_ch_req_queue;
  import mcash_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] count_o;
  logic             full_o;
  logic             empty_o;

  mcash_ch_req_queue_if ifc ();

  mcash_ch_req_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_if  (ifc.slave),
    .count_o (count_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         m_count  = 0;
  mcash_req_t exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output transfer must match the scoreboard head
  initial begin
    mcash_req_t got;
    mcash_req_t exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        got = '{op: ifc.out_req_op_o, addr: ifc.out_req_addr_o, data: ifc.out_req_data_o};
        if (ifc.out_req_valid_o) begin
          if (ifc.out_req_allowIn_i) begin
            if (exp_q.size() == 0) begin
              chk("stray_pop", {29'd0, got}, 128'd0);
            end else begin
              exp = exp_q.pop_front();
              chk("pop_payload", {29'd0, got}, {29'd0, exp});
            end
          end
        end else begin
          chk("empty_payload_zero", {29'd0, got}, 128'd0);
        end
      end
    end
  end

  // One cycle of stimulus; call at posedge+1, returns at next posedge+1
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [63:0] d, input logic oa, input logic r);
    logic acc, pop;
    rst                   = r;
    ifc.in_req_valid_i    = v;
    ifc.in_req_op_i       = op;
    ifc.in_req_addr_i     = a;
    ifc.in_req_data_i     = d;
    ifc.out_req_allowIn_i = oa;
    #1;
    chk("in_allowIn", {127'd0, ifc.in_req_allowIn_o}, {127'd0, (!r && m_count < DEPTH)});
    acc = v && !r && (m_count < DEPTH);
    pop = oa && !r && (m_count > 0);
    if (r) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      if (acc) exp_q.push_back('{op: op, addr: a, data: d});
      m_count = m_count + int'(acc) - int'(pop);
    end
    @(posedge clk);
    #1;
    chk("count",     {{(128-CNT_W){1'b0}}, count_o}, 128'(m_count));
    chk("full",      {127'd0, full_o},  {127'd0, (m_count == DEPTH)});
    chk("empty",     {127'd0, empty_o}, {127'd0, (m_count == 0)});
    chk("out_valid", {127'd0, ifc.out_req_valid_o}, {127'd0, (m_count > 0)});
  endtask

  task automatic idle(input logic oa);
    step(1'b0, 3'd0, 32'd0, 64'd0, oa, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_req_valid_i    = 1'b0;
    ifc.in_req_op_i       = '0;
    ifc.in_req_addr_i     = '0;
    ifc.in_req_data_i     = '0;
    ifc.out_req_allowIn_i = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 3'd0, 32'd0, 64'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 32'd0, 64'd0, 1'b0, 1'b1);

    // Single push, visible one cycle later, then gone
    step(1'b1, 3'd1, 32'h1000, 64'hDEADBEEF_00000001, 1'b1, 1'b0);
    chk("single_addr", {96'd0, ifc.out_req_addr_o}, {96'd0, 32'h1000});
    idle(1'b1);
    idle(1'b1);

    // Fill to full; the fifth request must be refused
    for (int i = 0; i < 5; i++)
      step(1'b1, 3'(i), 32'(i * 4), 64'(i + 100), 1'b0, 1'b0);
    chk("full_head_addr", {96'd0, ifc.out_req_addr_o}, 128'd0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Pop on a full queue with a push pending: only the pop happens
    for (int i = 0; i < 4; i++)
      step(1'b1, 3'd7, 32'h40 + 32'(i), 64'(i), 1'b0, 1'b0);
    step(1'b1, 3'd5, 32'h50, 64'h55, 1'b1, 1'b0);
    step(1'b1, 3'd6, 32'h54, 64'h66, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Back-to-back pushes through the pointer wrap
    for (int i = 0; i < 10; i++)
      step(1'b1, 3'(i), 32'(i), {32'hCAFE0000, 32'(i)}, 1'b1, 1'b0);
    idle(1'b1);

    // Backpressure: head must hold for three stalled cycles
    step(1'b1, 3'd2, 32'h20, 64'h2020_2020_2020_2020, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("stall_addr", {96'd0, ifc.out_req_addr_o}, {96'd0, 32'h20});
      chk("stall_data", {64'd0, ifc.out_req_data_o}, {64'd0, 64'h2020_2020_2020_2020});
    end
    idle(1'b1);

    // Reset mid-operation discards queued entries
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'd3, 32'h300 + 32'(i), 64'(i), 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 64'd0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 3'd4, 32'h400, 64'h4, 1'b1, 1'b0);
    idle(1'b1);

    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
